// File: rtl/jtag_tap_param.sv
// IEEE 1149.1 TAP with IR decode, BYPASS/IDCODE/user DR chains and a
// negedge-registered TDO.
module jtag_tap_param #(
  parameter int unsigned IR_WIDTH      = 4,
  parameter int unsigned NUM_USER_DR   = 2,
  parameter int unsigned USER_DR_WIDTH = 8,
  parameter logic [31:0] IDCODE_VAL    = 32'h1000_0001
) (
  input  logic                                   tclk,
  input  logic                                   trst,
  input  logic                                   tms,
  input  logic                                   tdi,
  output logic                                   tdo,
  output logic                                   tdo_en,
  output logic [3:0]                             tap_state,
  output logic [IR_WIDTH-1:0]                    ir_value,
  output logic                                   test_logic_reset,
  input  logic [NUM_USER_DR*USER_DR_WIDTH-1:0]   user_dr_in,
  output logic [NUM_USER_DR*USER_DR_WIDTH-1:0]   user_dr_out,
  output logic [NUM_USER_DR-1:0]                 user_update
);

  generate
    if (IDCODE_VAL[0] != 1'b1) begin : g_bad_idcode
      $error("jtag_tap_param: IDCODE_VAL bit 0 must be 1");
    end
    if (IR_WIDTH < 2) begin : g_bad_ir
      $error("jtag_tap_param: IR_WIDTH must be at least 2");
    end
    if (NUM_USER_DR < 1 || NUM_USER_DR > (2**IR_WIDTH) - 3) begin : g_bad_num
      $error("jtag_tap_param: NUM_USER_DR out of range");
    end
    if (USER_DR_WIDTH < 1) begin : g_bad_w
      $error("jtag_tap_param: USER_DR_WIDTH must be at least 1");
    end
  endgenerate

  typedef enum logic [3:0] {
    EX2_DR = 4'h0, EX1_DR = 4'h1, SH_DR  = 4'h2, PAU_DR = 4'h3,
    SEL_IR = 4'h4, UPD_DR = 4'h5, CAP_DR = 4'h6, SEL_DR = 4'h7,
    EX2_IR = 4'h8, EX1_IR = 4'h9, SH_IR  = 4'hA, PAU_IR = 4'hB,
    RTI    = 4'hC, UPD_IR = 4'hD, CAP_IR = 4'hE, TLR    = 4'hF
  } tap_state_e;

  tap_state_e state, next_state;
  logic tlr_next;

  logic [IR_WIDTH-1:0]      ir, ir_shift;
  logic                     bypass_reg;
  logic [31:0]              id_shift;
  logic [USER_DR_WIDTH-1:0] user_shift [NUM_USER_DR];

  logic                   sel_idcode, sel_bypass, dr_lsb;
  logic [NUM_USER_DR-1:0] sel_user;

  always_ff @(posedge tclk or negedge trst) begin
    if (!trst) state <= TLR;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      TLR:    next_state = tms ? TLR    : RTI;
      RTI:    next_state = tms ? SEL_DR : RTI;
      SEL_DR: next_state = tms ? SEL_IR : CAP_DR;
      CAP_DR: next_state = tms ? EX1_DR : SH_DR;
      SH_DR:  next_state = tms ? EX1_DR : SH_DR;
      EX1_DR: next_state = tms ? UPD_DR : PAU_DR;
      PAU_DR: next_state = tms ? EX2_DR : PAU_DR;
      EX2_DR: next_state = tms ? UPD_DR : SH_DR;
      UPD_DR: next_state = tms ? SEL_DR : RTI;
      SEL_IR: next_state = tms ? TLR    : CAP_IR;
      CAP_IR: next_state = tms ? EX1_IR : SH_IR;
      SH_IR:  next_state = tms ? EX1_IR : SH_IR;
      EX1_IR: next_state = tms ? UPD_IR : PAU_IR;
      PAU_IR: next_state = tms ? EX2_IR : PAU_IR;
      EX2_IR: next_state = tms ? UPD_IR : SH_IR;
      UPD_IR: next_state = tms ? SEL_DR : RTI;
      default: next_state = TLR;
    endcase
  end

  // Reset values are applied on the edge that lands in TLR, so they are
  // already visible while the controller sits there.
  assign tlr_next = (next_state == TLR);

  always_comb begin
    sel_idcode = (ir == IR_WIDTH'(1));
    sel_user   = '0;
    for (int unsigned k = 0; k < NUM_USER_DR; k++)
      sel_user[k] = (ir == IR_WIDTH'(k + 2));
    sel_bypass = !sel_idcode && !(|sel_user);
  end

  always_ff @(posedge tclk or negedge trst) begin
    if (!trst) begin
      ir       <= IR_WIDTH'(1);
      ir_shift <= '0;
    end else if (tlr_next) begin
      ir       <= IR_WIDTH'(1);
      ir_shift <= '0;
    end else begin
      case (state)
        CAP_IR:  ir_shift <= IR_WIDTH'(1);
        SH_IR:   ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
        UPD_IR:  ir       <= ir_shift;
        default: ;
      endcase
    end
  end

  always_ff @(posedge tclk or negedge trst) begin
    if (!trst) begin
      bypass_reg  <= 1'b0;
      id_shift    <= '0;
      user_dr_out <= '0;
      user_update <= '0;
      for (int unsigned k = 0; k < NUM_USER_DR; k++) user_shift[k] <= '0;
    end else if (tlr_next) begin
      bypass_reg  <= 1'b0;
      id_shift    <= '0;
      user_dr_out <= '0;
      user_update <= '0;
      for (int unsigned k = 0; k < NUM_USER_DR; k++) user_shift[k] <= '0;
    end else begin
      user_update <= '0;
      case (state)
        CAP_DR: begin
          if (sel_bypass) bypass_reg <= 1'b0;
          if (sel_idcode) id_shift   <= IDCODE_VAL;
          for (int unsigned k = 0; k < NUM_USER_DR; k++)
            if (sel_user[k])
              user_shift[k] <= user_dr_in[k*USER_DR_WIDTH +: USER_DR_WIDTH];
        end
        SH_DR: begin
          if (sel_bypass) bypass_reg <= tdi;
          if (sel_idcode) id_shift   <= {tdi, id_shift[31:1]};
          // Shift written arithmetically so a 1-bit user DR still elaborates.
          for (int unsigned k = 0; k < NUM_USER_DR; k++)
            if (sel_user[k])
              user_shift[k] <= (user_shift[k] >> 1) |
                               (USER_DR_WIDTH'(tdi) << (USER_DR_WIDTH - 1));
        end
        UPD_DR: begin
          for (int unsigned k = 0; k < NUM_USER_DR; k++)
            if (sel_user[k]) begin
              user_dr_out[k*USER_DR_WIDTH +: USER_DR_WIDTH] <= user_shift[k];
              user_update[k] <= 1'b1;
            end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    dr_lsb = bypass_reg;
    if (sel_idcode) dr_lsb = id_shift[0];
    for (int unsigned k = 0; k < NUM_USER_DR; k++)
      if (sel_user[k]) dr_lsb = user_shift[k][0];
  end

  always_ff @(negedge tclk or negedge trst) begin
    if (!trst) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else if (state == SH_DR) begin
      tdo    <= dr_lsb;
      tdo_en <= 1'b1;
    end else if (state == SH_IR) begin
      tdo    <= ir_shift[0];
      tdo_en <= 1'b1;
    end else begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end
  end

  assign tap_state        = state;
  assign ir_value         = ir;
  assign test_logic_reset = (state == TLR);

endmodule
